imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Loads a program image into the 4KB instruction SRAM after reset, then releases the core.
//   Receives a byte stream over a valid/ready interface and packs it into 32-bit words.
//   Drives the SRAM write port (cs/we/be/addr/din) and holds the RV32I core in reset during the load.
//   The SoC muxes these SRAM-write signals onto the imem wrapper while core_rst_n is low.
// PARAMETERS
//   DEPTH_WORDS     1024  instruction SRAM depth in 32-bit words; a legal word count is 1..DEPTH_WORDS
//   ADDR_W          10    SRAM word-address width; equals clog2(DEPTH_WORDS)
//   TIMEOUT_CYCLES  1000000  inter-byte timeout in cycles once a load has started; 0 disables it
// PORTS
//   clk          in   1       core clock
//   rst_n        in   1       asynchronous active-low reset
//   boot_en      in   1       1 = load an image after reset; 0 = skip loading and release the core at once
//   in_valid     in   1       byte-stream valid
//   in_data      in   8       byte-stream data
//   in_ready     out  1       byte accepted on a clk edge where in_valid && in_ready
//   mem_cs       out  1       SRAM chip select (write pulse)
//   mem_we       out  1       SRAM write enable
//   mem_be       out  4       byte enables: 4'b1111 while writing, 4'b0000 otherwise
//   mem_addr     out  ADDR_W  SRAM word address
//   mem_din      out  32      SRAM write data
//   core_rst_n   out  1       active-low reset to riscv_core; 1 only in DONE
//   boot_done    out  1       image loaded (or load skipped); sticky until rst_n
//   boot_err     out  1       load failed; sticky until rst_n
// BEHAVIOUR
//   Reset values: in_ready=0, mem_cs=0, mem_we=0, mem_be=0, mem_addr=0, mem_din=0,
//     core_rst_n=0, boot_done=0, boot_err=0, state=CHECK. All outputs are registered.
//   Stream format: CNT_LO, CNT_HI (16-bit word count N, little-endian), then 4*N data bytes, then CSUM.
//     Each data word is little-endian: the first byte goes to din[7:0].
//     CSUM is the XOR of all 4*N data bytes.
//   FSM:
//     CHECK: first cycle after reset release. boot_en=1 -> HDR0; boot_en=0 -> DONE.
//     HDR0: in_ready=1. Accept CNT_LO -> HDR1. Waits indefinitely; no timeout in this state.
//     HDR1: accept CNT_HI. If N==0 or N>DEPTH_WORDS -> ERR; otherwise -> DATA with word index k=0.
//     DATA: in_ready=1. A 2-bit byte counter packs each byte into a 32-bit assembly register.
//       On the edge accepting the 4th byte of word k: mem_cs=mem_we=1, mem_be=4'hF,
//         mem_addr=k, mem_din=assembled word. These hold for exactly the next cycle, then return to 0.
//       in_ready stays 1 during the write pulse, so back-to-back bytes are legal.
//       After word N-1 -> CSUM.
//     CSUM: accept one byte and compare it with the running XOR. Match -> DONE; mismatch -> ERR.
//     DONE: terminal state. in_ready=0, core_rst_n=1, boot_done=1.
//       These are registered on the same edge that enters DONE.
//     ERR: terminal state. in_ready=0, core_rst_n=0, boot_err=1. Left only via rst_n.
//   Timeout: a counter runs in HDR1, DATA and CSUM.
//     It clears on every accepted byte and counts each cycle with no byte accepted.
//     Reaching TIMEOUT_CYCLES -> ERR.
//   mem_addr width: k never exceeds DEPTH_WORDS-1 because N is range-checked in HDR1; no wrap.
//   rst_n asserted at any point (including mid-word or during a write pulse):
//     - every output and state returns to its reset value immediately (asynchronously);
//     - the partial word is discarded and the image must be resent from CNT_LO.
//   boot_done and boot_err are never 1 together.
// TESTING
//   T1: boot_en=0, release rst_n -> no mem_we pulse; core_rst_n=1 and boot_done=1 from the 2nd edge after release.
//   T2: N=2, stream 02 00 13 00 00 00 6F 00 00 00 7C ->
//       two write pulses: (addr0, 0x00000013) then (addr1, 0x0000006F); then boot_done=1, core_rst_n=1.
//   T3: same stream as T2 with CSUM=0x7D -> both writes occur; then boot_err=1, core_rst_n=0, in_ready=0.
//       Further bytes are ignored until rst_n.
//   T4: header 00 00 -> ERR after the 2nd byte with no writes; header 01 04 (N=1025) -> ERR.
//       Header 00 04 (N=1024) -> load proceeds and the last write is at addr 0x3FF.
//   T5: TIMEOUT_CYCLES=16, stall in_valid for 16 cycles after the 3rd data byte -> boot_err=1.
//       A 15-cycle stall does not error.
//   T6: random in_valid gaps across an N=8 load -> words match the source image.
//       Pulse rst_n mid-word 5 -> all outputs return to reset values; a full reload then succeeds.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a counted, checksummed byte stream, packs it into 32-bit words,
// writes them into the instruction SRAM and holds the core in reset until the image is loaded.
module imem_boot_loader #(
   parameter int DEPTH_WORDS    = 1024,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_en,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   output logic              core_rst_n,
   output logic              boot_done,
   output logic              boot_err
);

   localparam int          TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [31:0] TMO_LIM = TIMEOUT_CYCLES;

   typedef enum logic [2:0] {
      S_CHECK, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          cnt_lo_q, cnt_lo_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [ADDR_W-1:0]   k_q, k_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [23:0]         asm_q, asm_d;
   logic [7:0]          csum_q, csum_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                in_ready_q, in_ready_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         din_q, din_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                accept;
   logic                tmo_hit;
   logic [15:0]         n_word;

   always_comb begin
      accept     = in_valid && in_ready_q;
      n_word     = {in_data, cnt_lo_q};
      tmo_hit    = 1'b0;
      state_d    = state_q;
      cnt_lo_d   = cnt_lo_q;
      last_d     = last_q;
      k_d        = k_q;
      bcnt_d     = bcnt_q;
      asm_d      = asm_q;
      csum_d     = csum_q;
      tmo_d      = '0;
      we_d       = 1'b0;
      addr_d     = '0;
      din_d      = '0;

      // Idle-cycle counter only runs once a load has begun; any accepted byte clears it.
      if ((state_q inside {S_HDR1, S_DATA, S_CSUM}) && !accept) begin
         tmo_d   = tmo_q + TMO_W'(1);
         tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   (({{(32-TMO_W){1'b0}}, tmo_q} + 32'd1) >= TMO_LIM);
      end

      case (state_q)
         S_CHECK: state_d = boot_en ? S_HDR0 : S_DONE;
         S_HDR0: begin
            if (accept) begin
               cnt_lo_d = in_data;
               state_d  = S_HDR1;
            end
         end
         S_HDR1: begin
            if (accept) begin
               if ((n_word == 16'd0) || (n_word > 16'(DEPTH_WORDS))) begin
                  state_d = S_ERR;
               end else begin
                  last_d  = ADDR_W'(n_word - 16'd1);
                  k_d     = '0;
                  bcnt_d  = '0;
                  csum_d  = '0;
                  state_d = S_DATA;
               end
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end
         end
         S_DATA: begin
            if (accept) begin
               csum_d = csum_q ^ in_data;
               bcnt_d = bcnt_q + 2'd1;
               // Shift register: after three bytes asm_q holds {b2, b1, b0}.
               asm_d  = {in_data, asm_q[23:8]};
               if (bcnt_q == 2'd3) begin
                  we_d   = 1'b1;
                  addr_d = k_q;
                  din_d  = {in_data, asm_q};
                  k_d    = k_q + ADDR_W'(1);
                  if (k_q == last_q) state_d = S_CSUM;
               end
            end else if (tmo_hit) begin
               state_d = S_ERR;
            end
         end
         S_CSUM: begin
            if (accept)       state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            else if (tmo_hit) state_d = S_ERR;
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase

      in_ready_d = state_d inside {S_HDR0, S_HDR1, S_DATA, S_CSUM};
      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_CHECK;
         cnt_lo_q   <= '0;
         last_q     <= '0;
         k_q        <= '0;
         bcnt_q     <= '0;
         asm_q      <= '0;
         csum_q     <= '0;
         tmo_q      <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_lo_q   <= cnt_lo_d;
         last_q     <= last_d;
         k_q        <= k_d;
         bcnt_q     <= bcnt_d;
         asm_q      <= asm_d;
         csum_q     <= csum_d;
         tmo_q      <= tmo_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_cs     = we_q;
   assign mem_we     = we_q;
   assign mem_be     = {4{we_q}};
   assign mem_addr   = addr_q;
   assign mem_din    = din_q;
   assign core_rst_n = done_q;
   assign boot_done  = done_q;
   assign boot_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: image-level model (word image -> byte stream, expected write list)
// checked every cycle by a compare process, plus directed scenarios with literal expectations.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        boot_en = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_cs, mem_we, core_rst_n, boot_done, boot_err;
   logic [3:0]  mem_be;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [9:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         wq[$];
   logic [31:0] img [0:1023];
   logic [7:0]  strm[$];
   logic        prev_we = 1'b0;
   logic [9:0]  last_addr = '0;

   imem_boot_loader #(
      .DEPTH_WORDS(1024), .ADDR_W(10), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .boot_en(boot_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .core_rst_n(core_rst_n), .boot_done(boot_done), .boot_err(boot_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: every write pulse must match the head of the expected write list.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("cs_eq_we", 32'(mem_cs), 32'(mem_we));
         chk("be", 32'(mem_be), 32'({4{mem_we}}));
         chk("done_err_excl", 32'(boot_done & boot_err), 32'd0);
         chk("core_rst_n", 32'(core_rst_n), 32'(boot_done));
         if (mem_we) begin
            chk("pulse_len", 32'(prev_we), 32'd0);
            chk("write_expected", 32'(wq.size() != 0), 32'd1);
            if (wq.size() != 0) begin
               chk("wr_addr", 32'(mem_addr), 32'(wq[0].a));
               chk("wr_data", mem_din, wq[0].d);
               wq.delete(0);
            end
            last_addr <= mem_addr;
         end else begin
            chk("idle_addr", 32'(mem_addr), 32'd0);
            chk("idle_din", mem_din, 32'd0);
         end
         prev_we <= mem_we;
      end else begin
         prev_we <= 1'b0;
      end
   end

   task automatic chk_status(input string nm, input logic done, input logic err,
                             input logic core, input logic rdy);
      chk({nm, "_done"}, 32'(boot_done), 32'(done));
      chk({nm, "_err"}, 32'(boot_err), 32'(err));
      chk({nm, "_core_rst_n"}, 32'(core_rst_n), 32'(core));
      chk({nm, "_in_ready"}, 32'(in_ready), 32'(rdy));
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk_status(nm, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({nm, "_cs"}, 32'(mem_cs), 32'd0);
      chk({nm, "_we"}, 32'(mem_we), 32'd0);
      chk({nm, "_be"}, 32'(mem_be), 32'd0);
      chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
      chk({nm, "_din"}, mem_din, 32'd0);
   endtask

   task automatic do_reset(input logic be);
      in_valid = 1'b0;
      in_data  = 8'h00;
      boot_en  = be;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("reset");
      wq.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Model: word image -> little-endian byte stream with header and XOR checksum.
   task automatic build_stream(input int n_hdr, input int n_data, input bit bad);
      logic [7:0]  x, b;
      logic [15:0] h;
      h = 16'(n_hdr);
      strm.delete();
      strm.push_back(h[7:0]);
      strm.push_back(h[15:8]);
      x = 8'h00;
      for (int k = 0; k < n_data; k++) begin
         for (int j = 0; j < 4; j++) begin
            b = img[k][8*j +: 8];
            strm.push_back(b);
            x = x ^ b;
         end
      end
      if (n_data > 0) strm.push_back(bad ? (x ^ 8'h01) : x);
   endtask

   task automatic expect_writes(input int n);
      for (int k = 0; k < n; k++) wq.push_back('{a: 10'(k), d: img[k]});
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         chk("in_ready_wait", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_range(input int first, input int last, input int gapmax);
      for (int i = first; i <= last; i++)
         send_byte(strm[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [7:0] t2_lit [0:10];

   initial begin
      t2_lit = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
      for (int i = 0; i < 1024; i++) img[i] = 32'h0;

      // T1: boot_en=0 releases the core with no writes
      do_reset(1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      chk_status("t1", 1'b1, 1'b0, 1'b1, 1'b0);
      settle();
      chk_status("t1_hold", 1'b1, 1'b0, 1'b1, 1'b0);

      // T2: two-word image with good checksum
      do_reset(1'b1);
      img[0] = 32'h00000013;
      img[1] = 32'h0000006F;
      build_stream(2, 2, 1'b0);
      chk("t2_len", 32'(strm.size()), 32'd11);
      for (int i = 0; i < 11; i++) chk("t2_stream", 32'(strm[i]), 32'(t2_lit[i]));
      expect_writes(2);
      send_range(0, 10, 0);
      settle();
      chk_status("t2", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t2_writes_left", 32'(wq.size()), 32'd0);

      // T3: bad checksum, then further bytes are ignored
      do_reset(1'b1);
      build_stream(2, 2, 1'b1);
      chk("t3_csum", 32'(strm[10]), 32'h7D);
      expect_writes(2);
      send_range(0, 10, 0);
      settle();
      chk_status("t3", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_writes_left", 32'(wq.size()), 32'd0);
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_data = 8'(8'hA0 + i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk_status("t3_ignore", 1'b0, 1'b1, 1'b0, 1'b0);

      // T4: header range limits
      do_reset(1'b1);
      build_stream(0, 0, 1'b0);
      send_range(0, 1, 0);
      chk_status("t4_n0", 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset(1'b1);
      build_stream(1025, 0, 1'b0);
      chk("t4_hdr_lo", 32'(strm[0]), 32'h01);
      chk("t4_hdr_hi", 32'(strm[1]), 32'h04);
      send_range(0, 1, 0);
      chk_status("t4_n1025", 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset(1'b1);
      for (int i = 0; i < 1024; i++) img[i] = $urandom;
      build_stream(1024, 1024, 1'b0);
      expect_writes(1024);
      send_range(0, strm.size() - 1, 0);
      settle();
      chk_status("t4_n1024", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t4_writes_left", 32'(wq.size()), 32'd0);
      chk("t4_last_addr", 32'(last_addr), 32'h3FF);

      // T5: inter-byte timeout of 16 cycles
      do_reset(1'b1);
      build_stream(1, 1, 1'b0);
      send_range(0, 4, 0);
      repeat (15) @(posedge clk);
      #1;
      chk_status("t5_stall15", 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      chk_status("t5_stall16", 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset(1'b1);
      expect_writes(1);
      send_range(0, 4, 0);
      send_byte(strm[5], 15);
      send_byte(strm[6], 0);
      settle();
      chk_status("t5_ok", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_writes_left", 32'(wq.size()), 32'd0);

      // T6: random gaps, reset mid-word 5, full reload
      do_reset(1'b1);
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      build_stream(8, 8, 1'b0);
      expect_writes(8);
      send_range(0, 23, 4);
      settle();
      chk("t6_writes_before_rst", 32'(wq.size()), 32'd3);
      do_reset(1'b1);
      expect_writes(8);
      send_range(0, strm.size() - 1, 4);
      settle();
      chk_status("t6_reload", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("t6_writes_left", 32'(wq.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
